// File: rtl/ifetch_pkg.sv
// ifetch_pkg
//   Shared types and constants for the instruction fetch unit.
//   - ifetch_state_t : fetch controller states (IDLE, LOAD, RUN, HALT)
//   - OPC_W / OPC_HALT : opcode field width and the HALT opcode
//   - is_halt()      : opcode decode helper
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } ifetch_state_t;

  localparam int OPC_W = 4;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'b0110;

  function automatic logic is_halt(input logic [OPC_W-1:0] opc);
    return (opc == OPC_HALT);
  endfunction

endpackage

// File: rtl/ifetch_imem.sv
// ifetch_imem
//   Single-write / single-read instruction RAM, DEPTH x INSTR_W, synchronous
//   read, no reset on the array (block-RAM inferable).
// Ports
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address, sampled on the clock edge
//   rdata : registered read data (mem[raddr] as of the last edge)
module ifetch_imem #(
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4096,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Write-first: the final load beat can write the very word the fetch
  // stage starts reading on the same edge (e.g. address 0 after a wrap or
  // for a one-word program), so the new word must be forwarded.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch stage: loadable instruction memory, PC, halt/resume and redirect,
//   valid/ready output towards decode with a registered output stage.
// Ports
//   clk, rst                      : clock, async active-high reset
//   prog_vld/prog_data/prog_last  : program load stream, prog_rdy ready
//   prog_ovf                      : sticky, load wrapped past DEPTH words
//   br_vld/br_addr                : redirect pulse and target
//   resume                        : leave HALT, continue at pc+1
//   instr/instr_pc/instr_vld      : fetched word, its address, valid
//   instr_rdy                     : decode accepts instr
//   halted                        : registered (state == HALT)
//   perf_instr_cnt                : only with IFETCH_PERF_CNT_EN defined,
//                                   saturating count of accepted instrs
// Configuration macro: IFETCH_PERF_CNT_EN
module instruction_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4096,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_vld,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               prog_last,
  output logic               prog_rdy,
  output logic               prog_ovf,
  input  logic               br_vld,
  input  logic [ADDR_W-1:0]  br_addr,
  input  logic               resume,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_vld,
  input  logic               instr_rdy,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0]        perf_instr_cnt,
`endif
  output logic               halted
);

  ifetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               instr_vld_q, instr_vld_d;
  logic               prog_ovf_q, prog_ovf_d;
  logic               halted_q, halted_d;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [INSTR_W-1:0] mem_rdata;
  logic               beat;
  logic               hs;
  logic               fetch_ok;
  logic               rd_halt;
  logic               load_start;

  // The RAM is addressed with pc_d, so during any cycle mem_rdata already
  // holds mem[pc_q]; the HALT decision can then be made on the fetch cycle
  // itself and the word lands in instr on the following edge.
  ifetch_imem #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (prog_data),
    .raddr (pc_d),
    .rdata (mem_rdata)
  );

  assign prog_rdy = (state_q != RUN);
  assign beat     = prog_vld & prog_rdy;
  assign hs       = instr_vld_q & instr_rdy;
  assign fetch_ok = ~instr_vld_q | instr_rdy;
  assign rd_halt  = is_halt(mem_rdata[INSTR_W-1 -: OPC_W]);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wr_ptr_d    = wr_ptr_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    instr_vld_d = instr_vld_q;
    prog_ovf_d  = prog_ovf_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q;
    load_start  = 1'b0;

    case (state_q)
      IDLE, HALT: begin
        // prog_rdy is high here, so a presented beat is already accepted by
        // the sender; it takes precedence over redirect/resume in HALT.
        if (beat) begin
          load_start  = 1'b1;
          mem_we      = 1'b1;
          mem_waddr   = '0;
          wr_ptr_d    = ADDR_W'(1);
          instr_vld_d = 1'b0;
          prog_ovf_d  = 1'b0;
          if (prog_last) begin
            state_d = RUN;
            pc_d    = '0;
          end else begin
            state_d = LOAD;
          end
        end else if (state_q == HALT) begin
          if (hs) begin
            instr_vld_d = 1'b0;
          end
          if (br_vld) begin
            instr_vld_d = 1'b0;
            pc_d        = br_addr;
            state_d     = RUN;
          end else if (resume) begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = RUN;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          // Address 0 is only revisited in LOAD after the pointer wrapped.
          if (wr_ptr_q == '0) begin
            prog_ovf_d = 1'b1;
          end
          if (prog_last) begin
            state_d = RUN;
            pc_d    = '0;
          end
        end
      end
      RUN: begin
        if (br_vld) begin
          instr_vld_d = 1'b0;
          pc_d        = br_addr;
        end else if (fetch_ok) begin
          instr_d     = mem_rdata;
          instr_pc_d  = pc_q;
          instr_vld_d = 1'b1;
          if (rd_halt) begin
            state_d = HALT;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      wr_ptr_q    <= '0;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      instr_vld_q <= 1'b0;
      prog_ovf_q  <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      wr_ptr_q    <= wr_ptr_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      instr_vld_q <= instr_vld_d;
      prog_ovf_q  <= prog_ovf_d;
      halted_q    <= halted_d;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (load_start) begin
      perf_d = '0;
    end else if (hs && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_instr_cnt = perf_q;
`endif

  assign instr     = instr_q;
  assign instr_pc  = instr_pc_q;
  assign instr_vld = instr_vld_q;
  assign prog_ovf  = prog_ovf_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
//   Directed bench for instruction_fetch_unit (DEPTH reduced to 16 so the
//   load-wrap case is short). Opcodes in bits [31:28]: 1=ADD, 2=SUB, 6=HALT.
module tb_instruction_fetch_unit;

  localparam int INSTR_W = 32;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               prog_vld;
  logic [INSTR_W-1:0] prog_data;
  logic               prog_last;
  logic               prog_rdy;
  logic               prog_ovf;
  logic               br_vld;
  logic [ADDR_W-1:0]  br_addr;
  logic               resume;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_vld;
  logic               instr_rdy;
  logic               halted;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0]        perf_instr_cnt;
`endif

  instruction_fetch_unit #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_vld  (prog_vld),
    .prog_data (prog_data),
    .prog_last (prog_last),
    .prog_rdy  (prog_rdy),
    .prog_ovf  (prog_ovf),
    .br_vld    (br_vld),
    .br_addr   (br_addr),
    .resume    (resume),
    .instr     (instr),
    .instr_pc  (instr_pc),
    .instr_vld (instr_vld),
    .instr_rdy (instr_rdy),
`ifdef IFETCH_PERF_CNT_EN
    .perf_instr_cnt (perf_instr_cnt),
`endif
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [INSTR_W-1:0] prog_q [$];
  logic [INSTR_W-1:0] p1 [4];
  logic [INSTR_W-1:0] filler [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog_q.size(); i++) begin
      prog_vld  = 1'b1;
      prog_data = prog_q[i];
      prog_last = (i == prog_q.size() - 1);
      tick();
    end
    prog_vld  = 1'b0;
    prog_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    int exp_idx;

    p1 = '{32'h1000_00A0, 32'h2000_00A1, 32'h1000_00A2, 32'h6000_00A3};
    for (int i = 0; i < 16; i++) begin
      filler[i] = (i == 15) ? 32'h6000_000F : (32'h1000_0000 | 32'(i));
    end

    rst = 1'b1; prog_vld = 1'b0; prog_data = '0; prog_last = 1'b0;
    br_vld = 1'b0; br_addr = '0; resume = 1'b0; instr_rdy = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_vld",    instr_vld, 0);
    chk("rst_instr",  instr, 0);
    chk("rst_pc",     instr_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ovf",    prog_ovf, 0);
    chk("rst_rdy",    prog_rdy, 1);

    // Fill the whole memory so every later fetch reads defined data
    prog_q.delete();
    for (int i = 0; i < 16; i++) prog_q.push_back(filler[i]);
    load_prog();
    chk("fill_rdy_run", prog_rdy, 0);
    chk("fill_vld_run", instr_vld, 0);
    tick();
    chk("fill_first_vld", instr_vld, 1);
    chk("fill_first_pc",  instr_pc, 0);
    n = 0;
    while (!halted && n < 40) begin tick(); n++; end
    chk("fill_halt",       halted, 1);
    chk("fill_halt_pc",    instr_pc, 15);
    chk("fill_halt_instr", instr, 32'h6000_000F);

    // 1: {ADD,SUB,ADD,HALT}, rdy=1 -> one word per cycle
    prog_q.delete();
    for (int i = 0; i < 4; i++) prog_q.push_back(p1[i]);
    load_prog();
    chk("s1_halted_clr", halted, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("s1_vld%0d", k),   instr_vld, 1);
      chk($sformatf("s1_pc%0d", k),    instr_pc, k);
      chk($sformatf("s1_instr%0d", k), instr, p1[k]);
      chk($sformatf("s1_halted%0d", k), halted, (k == 3) ? 1 : 0);
    end
    tick();
    chk("s1_halt_acc_vld", instr_vld, 0);
    chk("s1_halt_rdy", prog_rdy, 1);
`ifdef IFETCH_PERF_CNT_EN
    chk("s1_perf", perf_instr_cnt, 4);
`endif

    // 2: same program, instr_rdy toggling
    load_prog();
    instr_rdy = 1'b0;
    tick();
    chk("s2_pc_first", instr_pc, 0);
    exp_idx = 0;
    for (int j = 0; j < 6; j++) begin
      instr_rdy = (j % 2 == 1);
      tick();
      if (instr_rdy) exp_idx++;
      chk($sformatf("s2_vld%0d", j),   instr_vld, 1);
      chk($sformatf("s2_pc%0d", j),    instr_pc, exp_idx);
      chk($sformatf("s2_instr%0d", j), instr, p1[exp_idx]);
    end
    chk("s2_halted", halted, 1);

    // 3: resume -> pc 4, then redirect to 1 drops the presented word
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("s3_res_vld", instr_vld, 0);
    chk("s3_res_halted", halted, 0);
    instr_rdy = 1'b0;
    tick();
    chk("s3_res_pc",    instr_pc, 4);
    chk("s3_res_instr", instr, filler[4]);
    tick();
    chk("s3_hold_pc", instr_pc, 4);
    br_vld = 1'b1; br_addr = 4'd1;
    tick();
    br_vld = 1'b0;
    chk("s3_br_drop", instr_vld, 0);
    tick();
    chk("s3_br_vld",   instr_vld, 1);
    chk("s3_br_pc",    instr_pc, 1);
    chk("s3_br_instr", instr, p1[1]);
    instr_rdy = 1'b1;
    tick();
    chk("s3_pc2", instr_pc, 2);
    tick();
    chk("s3_pc3", instr_pc, 3);
    chk("s3_halted", halted, 1);

    // 4: br_vld + resume together in HALT -> redirect wins
    br_vld = 1'b1; br_addr = 4'd0; resume = 1'b1;
    tick();
    br_vld = 1'b0; resume = 1'b0;
    chk("s4_vld", instr_vld, 0);
    chk("s4_halted", halted, 0);
    tick();
    chk("s4_pc",    instr_pc, 0);
    chk("s4_instr", instr, p1[0]);
    tick(); tick(); tick();
    chk("s4_pc3", instr_pc, 3);
    chk("s4_halted_again", halted, 1);

    // 5: DEPTH+1 beats -> overflow, mem[0] holds the last beat
    for (int i = 0; i <= DEPTH; i++) begin
      prog_vld  = 1'b1;
      prog_data = (i == DEPTH) ? 32'h1000_0200 :
                  (i == 2)     ? 32'h6000_0102 : (32'h1000_0100 | 32'(i));
      prog_last = (i == DEPTH);
      if (i == DEPTH) chk("s5_ovf_before", prog_ovf, 0);
      tick();
    end
    prog_vld = 1'b0; prog_last = 1'b0;
    chk("s5_ovf", prog_ovf, 1);
    tick();
    chk("s5_pc0",    instr_pc, 0);
    chk("s5_instr0", instr, 32'h1000_0200);
    tick();
    chk("s5_instr1", instr, 32'h1000_0101);
    tick();
    chk("s5_halted", halted, 1);
    chk("s5_halt_pc", instr_pc, 2);
    load_prog();
    chk("s5_ovf_clr", prog_ovf, 0);
    tick();
    chk("s5_reload_pc",    instr_pc, 0);
    chk("s5_reload_instr", instr, p1[0]);
    tick(); tick(); tick();
    chk("s5_reload_halt", halted, 1);

    // 6: reset mid-load and mid-run
    prog_vld = 1'b1; prog_data = p1[0]; prog_last = 1'b0;
    tick();
    prog_data = p1[1];
    tick();
    prog_data = p1[2];
    #2 rst = 1'b1;
    #1;
    chk("s6_load_rst_vld", instr_vld, 0);
    chk("s6_load_rst_rdy", prog_rdy, 1);
    chk("s6_load_rst_halted", halted, 0);
    prog_vld = 1'b0;
    #1 rst = 1'b0;
    tick();
    load_prog();
    tick(); tick();
    chk("s6_run_vld_pre", instr_vld, 1);
    chk("s6_run_pc_pre",  instr_pc, 1);
    #2 rst = 1'b1;
    #1;
    chk("s6_run_rst_vld",   instr_vld, 0);
    chk("s6_run_rst_rdy",   prog_rdy, 1);
    chk("s6_run_rst_pc",    instr_pc, 0);
    chk("s6_run_rst_instr", instr, 0);
`ifdef IFETCH_PERF_CNT_EN
    chk("s6_perf_rst", perf_instr_cnt, 0);
`endif
    #1 rst = 1'b0;
    tick();

    // Single-beat program goes straight IDLE -> RUN
    prog_q.delete();
    prog_q.push_back(32'h6000_0055);
    load_prog();
    chk("s7_one_rdy", prog_rdy, 0);
    tick();
    chk("s7_one_vld",    instr_vld, 1);
    chk("s7_one_pc",     instr_pc, 0);
    chk("s7_one_instr",  instr, 32'h6000_0055);
    chk("s7_one_halted", halted, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
